pipe_out_scheduler: RTL and testbench
=====================================

Name: pipe_out_scheduler

Overview:
Shares one block-throttled pipe-out endpoint (16-bit, host-read) between N first-word-fall-through source FIFOs on ti_clk. Each block is granted round-robin to one source with enough buffered data. The scheduler prepends a header word that identifies the source and a per-source sequence number, then streams the payload. It sits between the capture FIFOs and the host-interface pipe-out endpoint, next to the wire-in that carries its enable.

Parameters:
N, 4, number of sources (2..16)
BLOCK_WORDS, 256, words per pipe block including header (>=2)
LW, 10, width of each source level field

Ports:
clk  in  1  ti_clk domain clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; 0 = finish current block, then grant nothing
src_level  in  N*LW  words buffered per source; slice i = [i*LW +: LW]
src_data  in  N*16  FWFT head word per source
src_rd  out  N  one-cycle pop strobe per source
ep_read  in  1  host word-read strobe
ep_blockstrobe  in  1  host block-start pulse (informational)
ep_ready  out  1  a full block is available
ep_data  out  16  current word to host
grant_id  out  4  source of the current or last block
busy  out  1  state != IDLE
underrun_count  out  16  saturating count of ep_read while not ready

Behaviour:
- Reset values (async, reset_n low): state IDLE, ep_ready 0, ep_data 0, src_rd 0, grant_id 0, rr pointer 0, all seq counters 0, underrun_count 0, word counter 0.
- States: IDLE -> ARB -> READY -> STREAM -> IDLE.
- IDLE: if enable, go to ARB next cycle.
- ARB, one cycle: scan sources starting at rr pointer, wrapping mod N. Select the first i with src_level[i] >= BLOCK_WORDS-1.
  - Hit: latch grant_id=i, load ep_data={4'hA, i[3:0], seq[i]}, go to READY.
  - Miss: go to IDLE.
- READY: ep_ready=1 and stays 1 through STREAM until the last word is read. The first ep_read moves to STREAM.
- Word read rule: on each cycle with ep_read=1, the word in ep_data is consumed. On the next edge, ep_data takes src_data[grant_id] and src_rd[grant_id] pulses in that same ep_read cycle (combinational src_rd = ep_read & streaming-or-ready & words_left>1). Latency: data for read k+1 is valid one cycle after read k.
- Word counter counts reads 0..BLOCK_WORDS-1. Word 0 is the header.
- On the read of word BLOCK_WORDS-1:
  - no pop, ep_ready drops next edge
  - seq[grant_id] increments, wrapping 8'hFF->0
  - rr pointer = grant_id+1 mod N
  - state goes to IDLE
- Total pops per block: exactly BLOCK_WORDS-1.
- enable deassert mid-block: the block completes normally; no new ARB while enable=0.
- ep_read with ep_ready=0 (IDLE/ARB): no pop, no state change, ep_data unchanged, underrun_count increments and saturates at 16'hFFFF.
- src_level is not rechecked after grant. The source must hold the data it advertised.
- ep_blockstrobe has no effect on sequencing.
- Asynchronous reset mid-block aborts it. Partially read source data is lost, and seq numbers restart at 0.
- Minimum gap: 2 cycles (IDLE, ARB) between the last read of one block and ep_ready of the next.

Test Plan:
1. N=4, BLOCK_WORDS=8; only source 2 level=7, counting data 0x0100.. -> ep_ready after 2 cycles; reads return 0xA200, then 0x0100..0x0106; src_rd[2] pulses exactly 7 times; ep_ready low after 8th read.
2. All sources level=100, three consecutive blocks -> headers 0xA000, 0xA100, 0xA200; second round of source 0 header = 0xA001.
3. Only source 3 with 300 blocks -> seq wraps: block 257 header = 0xA300.
4. Level=6 (<BLOCK_WORDS-1) on all sources -> ep_ready stays 0; 5 ep_read pulses -> underrun_count=5, src_rd never asserted.
5. enable dropped after 3 reads of a block -> remaining 5 words delivered; no further ep_ready until enable=1.
6. reset_n low during STREAM word 4 -> ep_ready, src_rd, ep_data immediately 0; after release and re-grant, header seq=00.

Source files
------------

// File: rtl/pipe_out_scheduler_if.sv
// Handshake bundle between capture FIFOs, host pipe-out endpoint
// and the pipe-out scheduler.
interface pipe_out_scheduler_if #(
  parameter int N  = 4,
  parameter int LW = 10
);
  logic            enable;
  logic [N*LW-1:0] src_level;
  logic [N*16-1:0] src_data;
  logic [N-1:0]    src_rd;
  logic            ep_read;
  logic            ep_blockstrobe;
  logic            ep_ready;
  logic [15:0]     ep_data;
  logic [3:0]      grant_id;
  logic            busy;
  logic [15:0]     underrun_count;

  modport master (
    output enable, src_level, src_data,
    output ep_read, ep_blockstrobe,
    input  src_rd, ep_ready, ep_data,
    input  grant_id, busy, underrun_count
  );

  modport slave (
    input  enable, src_level, src_data,
    input  ep_read, ep_blockstrobe,
    output src_rd, ep_ready, ep_data,
    output grant_id, busy, underrun_count
  );
endinterface

// File: rtl/pipe_out_scheduler.sv
// Round-robin block scheduler sharing one 16-bit pipe-out endpoint
// between N FWFT sources; each block = header word + payload.
module pipe_out_scheduler #(
  parameter int N           = 4,
  parameter int BLOCK_WORDS = 256,
  parameter int LW          = 10
) (
  input logic clk,
  input logic reset_n,
  pipe_out_scheduler_if.slave bus
);
  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);
  localparam logic [31:0] THR = 32'(BLOCK_WORDS - 1);
  localparam logic [3:0] NM1 = 4'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ARB, S_READY, S_STREAM
  } state_t;

  state_t        r_state;
  logic          r_ready;
  logic [15:0]   r_data;
  logic [3:0]    r_grant;
  logic [3:0]    r_rr;
  logic [7:0]    r_seq [N];
  logic [15:0]   r_under;
  logic [CW-1:0] r_wcnt;

  logic          w_hit;
  logic [3:0]    w_sel;
  logic [3:0]    w_idx;
  logic [4:0]    w_sum;
  logic [LW-1:0] w_lvl;
  logic          w_xfer;
  logic          w_last;
  logic [N-1:0]  w_rd;
  logic          w_unused;

  // Scan downwards so the source closest to r_rr wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_sum = '0;
    w_idx = '0;
    w_lvl = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + 5'(k);
      if (w_sum >= 5'(N))
        w_sum = w_sum - 5'(N);
      w_idx = w_sum[3:0];
      w_lvl = bus.src_level[w_idx*LW +: LW];
      if (32'(w_lvl) >= THR) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_xfer = bus.ep_read &
    (r_state == S_READY || r_state == S_STREAM);
  assign w_last = (r_wcnt == LAST);

  always_comb begin
    w_rd = '0;
    if (w_xfer && !w_last)
      w_rd = N'(1) << r_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_rr    <= '0;
      r_under <= '0;
      r_wcnt  <= '0;
      for (int i = 0; i < N; i++)
        r_seq[i] <= '0;
    end else begin
      if (bus.ep_read && !r_ready &&
          r_under != 16'hFFFF)
        r_under <= r_under + 16'd1;
      unique case (r_state)
        S_IDLE: begin
          if (bus.enable)
            r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_hit) begin
            r_grant <= w_sel;
            r_data  <= {4'hA, w_sel, r_seq[w_sel]};
            r_ready <= 1'b1;
            r_wcnt  <= '0;
            r_state <= S_READY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READY, S_STREAM: begin
          if (bus.ep_read) begin
            if (w_last) begin
              r_ready <= 1'b0;
              r_seq[r_grant] <= r_seq[r_grant] + 8'd1;
              r_rr <= (r_grant == NM1) ?
                4'd0 : r_grant + 4'd1;
              r_wcnt  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_data  <= bus.src_data[r_grant*16 +: 16];
              r_wcnt  <= r_wcnt + CW'(1);
              r_state <= S_STREAM;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.src_rd         = w_rd;
  assign bus.ep_ready       = r_ready;
  assign bus.ep_data        = r_data;
  assign bus.grant_id       = r_grant;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.underrun_count = r_under;
  assign w_unused           = bus.ep_blockstrobe;
endmodule

// File: tb/tb_pipe_out_scheduler.sv
// Directed bench for pipe_out_scheduler with counting FWFT
// source models (N=4, BLOCK_WORDS=8).
module tb_pipe_out_scheduler;
  localparam int N  = 4;
  localparam int BW = 8;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipe_out_scheduler_if #(.N(N), .LW(LW)) bus ();

  pipe_out_scheduler #(
    .N(N), .BLOCK_WORDS(BW), .LW(LW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [15:0] base   [N];
  logic [15:0] popcnt [N] = '{default: 16'd0};
  logic [15:0] blk    [BW];
  int n_checks = 0;
  int n_fail   = 0;

  // Source head word = base + words popped so far.
  always_comb begin
    bus.src_data = '0;
    for (int i = 0; i < N; i++)
      bus.src_data[i*16 +: 16] = base[i] + popcnt[i];
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (bus.src_rd[i])
        popcnt[i] <= popcnt[i] + 16'd1;

  task automatic set_levels(input logic [9:0] l0,
    input logic [9:0] l1, input logic [9:0] l2,
    input logic [9:0] l3);
    bus.src_level = {l3, l2, l1, l0};
  endtask

  task automatic apply_reset();
    bus.enable = 1'b0;
    bus.ep_read = 1'b0;
    bus.ep_blockstrobe = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (bus.ep_ready === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic read_words(input int first, input int cnt);
    for (int k = first; k < first + cnt; k++) begin
      blk[k] = bus.ep_data;
      bus.ep_read = 1'b1;
      @(negedge clk);
    end
    bus.ep_read = 1'b0;
  endtask

  function automatic int pop_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(popcnt[i]);
    return s;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.ep_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %0h want 0", bus.ep_ready);
    end
    n_checks++;
    if (bus.ep_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0000", bus.ep_data);
    end
    n_checks++;
    if (bus.src_rd !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_src_rd got %h want 0", bus.src_rd);
    end
    n_checks++;
    if (bus.grant_id !== 4'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_grant_busy got %h/%b want 0/0",
        bus.grant_id, bus.busy);
    end
    n_checks++;
    if (bus.underrun_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_underrun got %h want 0000",
        bus.underrun_count);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    int tot;
    logic [15:0] p2;
    apply_reset();
    set_levels(10'd0, 10'd0, 10'd7, 10'd0);
    base[2] = 16'h0100 - popcnt[2];
    bus.enable = 1'b1;
    wait_ready(n);
    n_checks++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL single_latency got %0d want 2", n);
    end
    p2 = popcnt[2];
    tot = pop_total();
    read_words(0, BW);
    bus.enable = 1'b0;
    n_checks++;
    if (blk[0] !== 16'hA200) begin
      n_fail++;
      $display("FAIL single_header got %h want A200", blk[0]);
    end
    for (int k = 1; k < BW; k++) begin
      n_checks++;
      if (blk[k] !== 16'h0100 + 16'(k - 1)) begin
        n_fail++;
        $display("FAIL single_word%0d got %h want %h", k,
          blk[k], 16'h0100 + 16'(k - 1));
      end
    end
    n_checks++;
    if (bus.ep_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready_drop got %b want 0",
        bus.ep_ready);
    end
    n_checks++;
    if (popcnt[2] - p2 !== 16'd7 || pop_total() - tot != 7) begin
      n_fail++;
      $display("FAIL single_pops got %0d/%0d want 7/7",
        popcnt[2] - p2, pop_total() - tot);
    end
    n_checks++;
    if (bus.grant_id !== 4'd2) begin
      n_fail++;
      $display("FAIL single_grant got %0d want 2", bus.grant_id);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int s;
    logic [15:0] ps;
    logic [15:0] exp;
    apply_reset();
    set_levels(10'd100, 10'd100, 10'd100, 10'd100);
    for (int i = 0; i < N; i++)
      base[i] = 16'(i) << 12;
    bus.enable = 1'b1;
    bus.ep_blockstrobe = 1'b1;
    for (int b = 0; b < 5; b++) begin
      wait_ready(n);
      n_checks++;
      if (n != 2) begin
        n_fail++;
        $display("FAIL rr_gap%0d got %0d want 2", b, n);
      end
      s = b % N;
      ps = popcnt[s];
      read_words(0, BW);
      exp = {4'hA, 4'(s), 8'(b / N)};
      n_checks++;
      if (blk[0] !== exp) begin
        n_fail++;
        $display("FAIL rr_header%0d got %h want %h", b,
          blk[0], exp);
      end
      n_checks++;
      if (blk[1] !== base[s] + ps ||
          blk[7] !== base[s] + ps + 16'd6) begin
        n_fail++;
        $display("FAIL rr_payload%0d got %h..%h want %h..%h",
          b, blk[1], blk[7], base[s] + ps,
          base[s] + ps + 16'd6);
      end
    end
    bus.enable = 1'b0;
    bus.ep_blockstrobe = 1'b0;
  endtask

  task automatic test_seq_wrap();
    int n;
    logic [15:0] exp;
    apply_reset();
    set_levels(10'd0, 10'd0, 10'd0, 10'd7);
    base[3] = 16'h3000;
    bus.enable = 1'b1;
    for (int b = 1; b <= 300; b++) begin
      wait_ready(n);
      n_checks++;
      if (n < 0) begin
        n_fail++;
        $display("FAIL wrap_timeout block %0d got none want ready",
          b);
        break;
      end
      read_words(0, BW);
      exp = {8'hA3, 8'(b - 1)};
      n_checks++;
      if (blk[0] !== exp) begin
        n_fail++;
        $display("FAIL wrap_header%0d got %h want %h", b,
          blk[0], exp);
      end
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_underrun();
    int tot;
    bit seen;
    apply_reset();
    set_levels(10'd6, 10'd6, 10'd6, 10'd6);
    bus.enable = 1'b1;
    tot = pop_total();
    seen = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bus.ep_read = 1'b1;
      if (bus.ep_ready !== 1'b0) seen = 1'b1;
      @(negedge clk);
      bus.ep_read = 1'b0;
      if (bus.ep_ready !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bus.underrun_count !== 16'd5) begin
      n_fail++;
      $display("FAIL underrun_count got %0d want 5",
        bus.underrun_count);
    end
    n_checks++;
    if (seen || pop_total() != tot) begin
      n_fail++;
      $display("FAIL underrun_idle got ready=%b pops=%0d want 0/0",
        seen, pop_total() - tot);
    end
    n_checks++;
    if (bus.ep_data !== 16'h0) begin
      n_fail++;
      $display("FAIL underrun_data got %h want 0000", bus.ep_data);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n;
    bit seen;
    logic [15:0] p1;
    apply_reset();
    set_levels(10'd0, 10'd7, 10'd0, 10'd0);
    base[1] = 16'h2000 - popcnt[1];
    bus.enable = 1'b1;
    wait_ready(n);
    p1 = popcnt[1];
    read_words(0, 3);
    bus.enable = 1'b0;
    read_words(3, 5);
    n_checks++;
    if (blk[0] !== 16'hA100 || blk[3] !== 16'h2002 ||
        blk[7] !== 16'h2006) begin
      n_fail++;
      $display("FAIL drop_words got %h %h %h want A100 2002 2006",
        blk[0], blk[3], blk[7]);
    end
    n_checks++;
    if (popcnt[1] - p1 !== 16'd7) begin
      n_fail++;
      $display("FAIL drop_pops got %0d want 7", popcnt[1] - p1);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ep_ready !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle got ready=%b busy=%b want 0/0",
        seen, bus.busy);
    end
    bus.enable = 1'b1;
    wait_ready(n);
    n_checks++;
    if (n != 2 || bus.ep_data !== 16'hA101) begin
      n_fail++;
      $display("FAIL drop_regrant got %0d/%h want 2/A101",
        n, bus.ep_data);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_reset_mid_block();
    int n;
    apply_reset();
    set_levels(10'd7, 10'd0, 10'd0, 10'd0);
    base[0] = 16'h4000;
    bus.enable = 1'b1;
    wait_ready(n);
    read_words(0, BW);
    wait_ready(n);
    n_checks++;
    if (blk[0] !== 16'hA000 || bus.ep_data !== 16'hA001) begin
      n_fail++;
      $display("FAIL midrst_pre got %h/%h want A000/A001",
        blk[0], bus.ep_data);
    end
    read_words(0, 4);
    bus.ep_read = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ep_ready !== 1'b0 || bus.src_rd !== 4'h0 ||
        bus.ep_data !== 16'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear got %b %h %h %b want 0 0 0000 0",
        bus.ep_ready, bus.src_rd, bus.ep_data, bus.busy);
    end
    bus.ep_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready(n);
    n_checks++;
    if (n != 2 || bus.ep_data !== 16'hA000 ||
        bus.grant_id !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_regrant got %0d/%h/%0d want 2/A000/0",
        n, bus.ep_data, bus.grant_id);
    end
    bus.enable = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.ep_read = 1'b0;
    bus.ep_blockstrobe = 1'b0;
    bus.src_level = '0;
    for (int i = 0; i < N; i++) base[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_seq_wrap();
    test_underrun();
    test_enable_drop();
    test_reset_mid_block();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end
endmodule
